bsnn_spike_encoder: RTL and testbench

BSNN_SPIKE_ENCODER -- requirements
Module: bsnn_spike_encoder

---
 rtl/bsnn_spike_encoder.sv | 133 +++++++++++++
 tb/tb_bsnn_spike_encoder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsnn_spike_encoder.sv
// bsnn_spike_encoder: rate-codes four 8-bit intensities into WINDOW spike timesteps.
// Define BSNN_ENC_DETERMINISTIC_EN for carry-accumulator coding instead of LFSR comparison.
module bsnn_spike_encoder #(
    parameter int unsigned WINDOW    = 16,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] pixel_data,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    input  logic        en,
    output logic [3:0]  spike_out,
    output logic        spike_valid,
    output logic        window_done
);

    // state  | meaning
    // IDLE   | waiting for a sample; pixel_ready high
    // ENCODE | one timestep emitted per cycle with en high
    typedef enum logic {IDLE, ENCODE} state_t;

    localparam logic [7:0] T_LAST = 8'(WINDOW - 1);

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            emit;
    logic            last;
    logic [7:0]      t_cnt;
    logic [3:0][7:0] intensity;
    logic [3:0]      spike_nxt;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        emit      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (pixel_valid) begin
                    accept    = 1'b1;
                    state_nxt = ENCODE;
                end
            end
            ENCODE: begin
                if (en) begin
                    emit = 1'b1;
                    if (t_cnt == T_LAST) begin
                        last      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pixel_ready = (state == IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

`ifdef BSNN_ENC_DETERMINISTIC_EN
    // The ninth accumulator bit is the carry, which is registered directly as the spike.
    logic [3:0][7:0] acc;
    logic [3:0][8:0] acc_sum;

    always_comb begin
        acc_sum   = '0;
        spike_nxt = '0;
        for (int i = 0; i < 4; i++) begin
            acc_sum[i]   = {1'b0, acc[i]} + {1'b0, intensity[i]};
            spike_nxt[i] = acc_sum[i][8];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc <= '0;
        end else if (accept) begin
            acc <= '0;
        end else if (emit) begin
            for (int i = 0; i < 4; i++) acc[i] <= acc_sum[i][7:0];
        end
    end
`else
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    // An all-zero Galois LFSR never leaves zero, so a zero seed is promoted to 1.
    localparam logic [31:0] SEED_EFF  = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

    logic [31:0] lfsr;
    logic [31:0] lfsr_nxt;

    always_comb begin
        lfsr_nxt  = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
        spike_nxt = '0;
        for (int i = 0; i < 4; i++) spike_nxt[i] = (intensity[i] > lfsr[8*i +: 8]);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)       lfsr <= SEED_EFF;
        else if (emit) lfsr <= lfsr_nxt;
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            t_cnt       <= '0;
            intensity   <= '0;
            spike_out   <= '0;
            spike_valid <= 1'b0;
            window_done <= 1'b0;
        end else begin
            spike_out   <= '0;
            spike_valid <= 1'b0;
            window_done <= 1'b0;
            if (accept) begin
                intensity <= pixel_data;
                t_cnt     <= '0;
            end
            if (emit) begin
                spike_out   <= spike_nxt;
                spike_valid <= 1'b1;
                window_done <= last;
                t_cnt       <= t_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_bsnn_spike_encoder.sv
// Directed bench for bsnn_spike_encoder: windows of 16, 1, 4 and 256 timesteps,
// checked against a bench-side LFSR / carry-accumulator model (follows BSNN_ENC_DETERMINISTIC_EN).
module tb_bsnn_spike_encoder;

    logic CLK;
    logic RST;

    logic [31:0] w16_data, w1_data, w4_data, w256_data;
    logic        w16_valid, w1_valid, w4_valid, w256_valid;
    logic        w16_en, w1_en, w4_en, w256_en;
    logic        w16_ready, w1_ready, w4_ready, w256_ready;
    logic [3:0]  w16_spk, w1_spk, w4_spk, w256_spk;
    logic        w16_sv, w1_sv, w4_sv, w256_sv;
    logic        w16_done, w1_done, w4_done, w256_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per DUT: 0=w16, 1=w1, 2=w4, 3=w256
    logic [31:0]     m_lfsr [4];
    logic [3:0][7:0] m_acc  [4];
    logic [3:0]      exp_s;
    int              cnt [4];
    int              exp_cnt [4] = '{0, 4, 8, 15};
    logic [31:0]     w4_samples [3] = '{32'h80FF_4010, 32'hFFFF_FFFF, 32'h00C0_0180};
    logic [31:0]     w1_samples [2] = '{32'h0000_0080, 32'h0101_0101};

    bsnn_spike_encoder #(.WINDOW(16)) u_w16 (
        .CLK(CLK), .RST(RST), .pixel_data(w16_data), .pixel_valid(w16_valid),
        .pixel_ready(w16_ready), .en(w16_en), .spike_out(w16_spk),
        .spike_valid(w16_sv), .window_done(w16_done));

    bsnn_spike_encoder #(.WINDOW(1), .LFSR_SEED(32'h0)) u_w1 (
        .CLK(CLK), .RST(RST), .pixel_data(w1_data), .pixel_valid(w1_valid),
        .pixel_ready(w1_ready), .en(w1_en), .spike_out(w1_spk),
        .spike_valid(w1_sv), .window_done(w1_done));

    bsnn_spike_encoder #(.WINDOW(4)) u_w4 (
        .CLK(CLK), .RST(RST), .pixel_data(w4_data), .pixel_valid(w4_valid),
        .pixel_ready(w4_ready), .en(w4_en), .spike_out(w4_spk),
        .spike_valid(w4_sv), .window_done(w4_done));

    bsnn_spike_encoder #(.WINDOW(256)) u_w256 (
        .CLK(CLK), .RST(RST), .pixel_data(w256_data), .pixel_valid(w256_valid),
        .pixel_ready(w256_ready), .en(w256_en), .spike_out(w256_spk),
        .spike_valid(w256_sv), .window_done(w256_done));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        m_lfsr[0] = 32'hACE1_2468;
        m_lfsr[1] = 32'h0000_0001;
        m_lfsr[2] = 32'hACE1_2468;
        m_lfsr[3] = 32'hACE1_2468;
        for (int d = 0; d < 4; d++) m_acc[d] = '0;
    endtask

    task automatic model_accept(input int d);
        m_acc[d] = '0;
    endtask

    task automatic model_emit(input int d, input logic [31:0] pix, output logic [3:0] e);
        logic [8:0] sum;
        e = '0;
        for (int i = 0; i < 4; i++) begin
`ifdef BSNN_ENC_DETERMINISTIC_EN
            sum         = {1'b0, m_acc[d][i]} + {1'b0, pix[8*i +: 8]};
            e[i]        = sum[8];
            m_acc[d][i] = sum[7:0];
`else
            e[i] = (pix[8*i +: 8] > m_lfsr[d][8*i +: 8]);
`endif
        end
`ifndef BSNN_ENC_DETERMINISTIC_EN
        if (m_lfsr[d][0]) m_lfsr[d] = (m_lfsr[d] >> 1) ^ 32'h8020_0003;
        else              m_lfsr[d] = m_lfsr[d] >> 1;
`endif
    endtask

    task automatic w16_accept(input logic [31:0] pix);
        w16_data  = pix;
        w16_valid = 1'b1;
        tick();
        model_accept(0);
        check_eq("w16_accept_ready", w16_ready, 1'b0);
        check_eq("w16_accept_sv", w16_sv, 1'b0);
        w16_valid = 1'b0;
        w16_data  = 32'hDEAD_BEEF;
    endtask

    task automatic w16_window(input logic [31:0] pix, input bit toggle);
        int n_edges;
        n_edges = toggle ? 31 : 16;
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        for (int k = 0; k < n_edges; k++) begin
            w16_en = toggle ? (k % 2 == 0) : 1'b1;
            tick();
            if (w16_en) begin
                model_emit(0, pix, exp_s);
                check_eq("w16_sv", w16_sv, 1'b1);
                check_eq("w16_spk", w16_spk, exp_s);
                for (int c = 0; c < 4; c++) cnt[c] += int'(w16_spk[c]);
            end else begin
                check_eq("w16_idle_sv", w16_sv, 1'b0);
                check_eq("w16_idle_spk", w16_spk, 4'h0);
            end
            check_eq("w16_done", w16_done, (k == n_edges - 1));
        end
        w16_en = 1'b1;
        check_eq("w16_ready_last", w16_ready, 1'b1);
    endtask

    task automatic w16_counts();
`ifdef BSNN_ENC_DETERMINISTIC_EN
        for (int c = 0; c < 4; c++) check_eq("w16_count", cnt[c], exp_cnt[c]);
`endif
    endtask

    initial begin
        RST = 1'b1;
        {w16_valid, w1_valid, w4_valid, w256_valid} = '0;
        {w16_en, w1_en, w4_en, w256_en} = 4'hF;
        w16_data = '0; w1_data = '0; w4_data = '0; w256_data = '0;
        model_reset();
        tick();
        tick();
        check_eq("rst_ready", w16_ready, 1'b1);
        check_eq("rst_spk", w16_spk, 4'h0);
        check_eq("rst_sv", w16_sv, 1'b0);
        check_eq("rst_done", w16_done, 1'b0);

        // Accept on the first edge after reset release, then a full window
        RST = 1'b0;
        w16_accept(32'hFF80_4000);
        w16_window(32'hFF80_4000, 1'b0);
        w16_counts();

        // Back-to-back sample with en toggling every cycle
        w16_accept(32'hFF80_4000);
        w16_window(32'hFF80_4000, 1'b1);
        w16_counts();

        // Zero intensity never spikes
        w16_accept(32'h0000_0000);
        w16_window(32'h0000_0000, 1'b0);
        for (int c = 0; c < 4; c++) check_eq("w16_zero_count", cnt[c], 0);

        // Reset mid-window after 7 timesteps
        w16_accept(32'hFF80_4000);
        for (int k = 0; k < 7; k++) begin
            tick();
            model_emit(0, 32'hFF80_4000, exp_s);
            check_eq("w16_abort_sv", w16_sv, 1'b1);
            check_eq("w16_abort_spk", w16_spk, exp_s);
            check_eq("w16_abort_done", w16_done, 1'b0);
        end
        #2 RST = 1'b1;
        #1;
        check_eq("async_rst_ready", w16_ready, 1'b1);
        check_eq("async_rst_sv", w16_sv, 1'b0);
        check_eq("async_rst_spk", w16_spk, 4'h0);
        check_eq("async_rst_done", w16_done, 1'b0);
        tick();
        check_eq("in_rst_done", w16_done, 1'b0);
        check_eq("in_rst_sv", w16_sv, 1'b0);
        RST = 1'b0;
        model_reset();
        w16_accept(32'hFF80_4000);
        w16_window(32'hFF80_4000, 1'b0);
        w16_counts();

        // WINDOW=1 with zero seed
        for (int s = 0; s < 2; s++) begin
            w1_data  = w1_samples[s];
            w1_valid = 1'b1;
            tick();
            model_accept(1);
            check_eq("w1_accept_ready", w1_ready, 1'b0);
            check_eq("w1_accept_sv", w1_sv, 1'b0);
            w1_valid = 1'b0;
            tick();
            model_emit(1, w1_samples[s], exp_s);
            check_eq("w1_sv", w1_sv, 1'b1);
            check_eq("w1_spk", w1_spk, exp_s);
            check_eq("w1_done", w1_done, 1'b1);
            check_eq("w1_ready", w1_ready, 1'b1);
        end
`ifdef BSNN_ENC_DETERMINISTIC_EN
        check_eq("w1_det_spk", w1_spk, 4'h0);
`else
        check_eq("w1_seed1_spk", w1_spk, 4'b0010);
`endif

        // WINDOW=4 with pixel_valid held high; data changes while encoding are ignored
        w4_data  = w4_samples[0];
        w4_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            for (int ph = 0; ph < 5; ph++) begin
                tick();
                if (ph == 0) begin
                    model_accept(2);
                    check_eq("w4_accept_ready", w4_ready, 1'b0);
                    check_eq("w4_accept_sv", w4_sv, 1'b0);
                    w4_data = ~w4_samples[s];
                end else begin
                    model_emit(2, w4_samples[s], exp_s);
                    check_eq("w4_sv", w4_sv, 1'b1);
                    check_eq("w4_spk", w4_spk, exp_s);
                    check_eq("w4_done", w4_done, (ph == 4));
                    check_eq("w4_ready", w4_ready, (ph == 4));
                    if (ph == 4 && s < 2) w4_data = w4_samples[s + 1];
                end
            end
        end
        w4_valid = 1'b0;

        // WINDOW=256, full intensity
        w256_data  = 32'hFFFF_FFFF;
        w256_valid = 1'b1;
        tick();
        model_accept(3);
        check_eq("w256_accept_ready", w256_ready, 1'b0);
        w256_valid = 1'b0;
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        for (int k = 0; k < 256; k++) begin
            tick();
            model_emit(3, 32'hFFFF_FFFF, exp_s);
            check_eq("w256_sv", w256_sv, 1'b1);
            check_eq("w256_spk", w256_spk, exp_s);
            check_eq("w256_done", w256_done, (k == 255));
            for (int c = 0; c < 4; c++) cnt[c] += int'(w256_spk[c]);
        end
        tick();
        check_eq("w256_post_sv", w256_sv, 1'b0);
        check_eq("w256_post_ready", w256_ready, 1'b1);
        for (int c = 0; c < 4; c++) begin
`ifdef BSNN_ENC_DETERMINISTIC_EN
            check_eq("w256_count", cnt[c], 255);
`else
            check_eq("w256_count_ge250", (cnt[c] >= 250), 1'b1);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
